// File: rtl/sha256_arbiter.sv
// Two-requester round-robin arbiter in front of a single SHA-256 core.
// The owner streams 16 message words to the core, then collects 32 hash bytes.
module sha256_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WORD_GAP     = 3,
  parameter int unsigned WAIT_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_i,
  input  logic [1:0]            word_valid_i,
  input  logic [DATA_WIDTH-1:0] word0_i,
  input  logic [DATA_WIDTH-1:0] word1_i,
  output logic [1:0]            word_ready_o,
  output logic [1:0]            grant_o,
  output logic [DATA_WIDTH-1:0] core_msg_o,
  output logic                  core_dv_o,
  input  logic [7:0]            core_hash_i,
  input  logic                  core_dv_i,
  output logic [7:0]            hash_byte_o,
  output logic [1:0]            hash_dv_o,
  output logic [1:0]            done_o,
  output logic [1:0]            err_o
);

  localparam int unsigned GapW = (WORD_GAP > 1) ? $clog2(WORD_GAP) : 1;
  localparam int unsigned ToW  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StGrant   = 3'd1,
    StLoad    = 3'd2,
    StWait    = 3'd3,
    StReturn  = 3'd4,
    StRelease = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_owner_q, last_owner_d;
  logic [3:0]            word_cnt_q, word_cnt_d;
  logic                  seen16_q, seen16_d;
  logic [GapW-1:0]       gap_q, gap_d;
  logic [ToW-1:0]        to_cnt_q, to_cnt_d;
  logic [4:0]            byte_cnt_q, byte_cnt_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            word_ready_q, word_ready_d;
  logic [1:0]            hash_dv_q, hash_dv_d;
  logic [1:0]            done_q, done_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_WIDTH-1:0] msg_q, msg_d;
  logic                  core_dv_q, core_dv_d;
  logic [7:0]            hash_byte_q, hash_byte_d;

  logic       win;
  logic [1:0] owner_oh;
  logic       load_fire, load_done, wait_hit, wait_timeout, byte_fire, byte_last;

  // On a tie the requester that did not own the core last time wins.
  always_comb begin
    win = ~last_owner_q;
    if (req_i == 2'b01) begin
      win = 1'b0;
    end else if (req_i == 2'b10) begin
      win = 1'b1;
    end
  end

  assign owner_oh     = {owner_q, ~owner_q};
  assign load_fire    = (state_q == StLoad) && !seen16_q && (gap_q == '0) &&
                        word_valid_i[owner_q];
  assign load_done    = (state_q == StLoad) && seen16_q && (gap_q == '0);
  assign wait_hit     = (state_q == StWait) && core_dv_i;
  assign wait_timeout = (state_q == StWait) && !core_dv_i &&
                        (to_cnt_q == ToW'(WAIT_TIMEOUT - 1));
  assign byte_fire    = (state_q == StReturn) && core_dv_i;
  assign byte_last    = byte_fire && (byte_cnt_q == 5'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      word_cnt_q   <= '0;
      seen16_q     <= 1'b0;
      gap_q        <= '0;
      to_cnt_q     <= '0;
      byte_cnt_q   <= '0;
      grant_q      <= '0;
      word_ready_q <= '0;
      hash_dv_q    <= '0;
      done_q       <= '0;
      err_q        <= '0;
      msg_q        <= '0;
      core_dv_q    <= 1'b0;
      hash_byte_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      word_cnt_q   <= word_cnt_d;
      seen16_q     <= seen16_d;
      gap_q        <= gap_d;
      to_cnt_q     <= to_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      grant_q      <= grant_d;
      word_ready_q <= word_ready_d;
      hash_dv_q    <= hash_dv_d;
      done_q       <= done_d;
      err_q        <= err_d;
      msg_q        <= msg_d;
      core_dv_q    <= core_dv_d;
      hash_byte_q  <= hash_byte_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (req_i != 2'b00) state_d = StGrant;
      StGrant:   state_d = StLoad;
      StLoad:    if (load_done) state_d = StWait;
      StWait: begin
        if (wait_hit) begin
          state_d = StReturn;
        end else if (wait_timeout) begin
          state_d = StRelease;
        end
      end
      StReturn:  if (byte_last) state_d = StRelease;
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    word_cnt_d   = word_cnt_q;
    seen16_d     = seen16_q;
    gap_d        = gap_q;
    to_cnt_d     = to_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    grant_d      = grant_q;
    msg_d        = msg_q;
    hash_byte_d  = hash_byte_q;
    word_ready_d = '0;
    core_dv_d    = 1'b0;
    hash_dv_d    = '0;
    done_d       = '0;
    err_d        = '0;
    case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          owner_d = win;
          grant_d = {win, ~win};
        end
      end
      StGrant: begin
        word_cnt_d = '0;
        seen16_d   = 1'b0;
        gap_d      = '0;
        to_cnt_d   = '0;
        byte_cnt_d = '0;
      end
      StLoad: begin
        if (load_fire) begin
          msg_d        = owner_q ? word1_i : word0_i;
          core_dv_d    = 1'b1;
          word_ready_d = owner_oh;
          gap_d        = GapW'(WORD_GAP - 1);
          word_cnt_d   = word_cnt_q + 4'd1;
          // Count wraps to zero on the 16th word; the flag remembers it.
          if (word_cnt_q == 4'd15) seen16_d = 1'b1;
        end else if (gap_q != '0) begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StWait: begin
        if (wait_hit) begin
          byte_cnt_d = '0;
        end else if (wait_timeout) begin
          err_d = owner_oh;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
      StReturn: begin
        if (byte_fire) begin
          hash_byte_d = core_hash_i;
          hash_dv_d   = owner_oh;
          byte_cnt_d  = byte_cnt_q + 5'd1;
          if (byte_last) done_d = owner_oh;
        end
      end
      StRelease: begin
        last_owner_d = owner_q;
        grant_d      = '0;
      end
      default: begin
        owner_d      = 1'b0;
        last_owner_d = 1'b1;
        word_cnt_d   = '0;
        seen16_d     = 1'b0;
        gap_d        = '0;
        to_cnt_d     = '0;
        byte_cnt_d   = '0;
        grant_d      = '0;
        msg_d        = '0;
        hash_byte_d  = '0;
      end
    endcase
  end

  assign word_ready_o = word_ready_q;
  assign grant_o      = grant_q;
  assign core_msg_o   = msg_q;
  assign core_dv_o    = core_dv_q;
  assign hash_byte_o  = hash_byte_q;
  assign hash_dv_o    = hash_dv_q;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: doc/sha256_arbiter.md
SHA256_ARBITER -- requirements
Module: sha256_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, message word width.
REQ-002 Parameter WORD_GAP, default 3, cycles each word is held on core_msg_o (min 3).
REQ-003 Parameter WAIT_TIMEOUT, default 4096, maximum cycles waiting for first hash byte.
REQ-004 Ports, one per line (name  direction  width  meaning):
  clk  input  1  single clock, rising edge
  rst_n  input  1  asynchronous active-low reset
  req_i  input  2  per-requester access request, bit n = requester n
  word_valid_i  input  2  per-requester message word valid
  word0_i  input  DATA_WIDTH  requester 0 message word
  word1_i  input  DATA_WIDTH  requester 1 message word
  word_ready_o  output  2  per-requester word accepted (one-cycle pulse)
  grant_o  output  2  one-hot owner of the core, 0 when idle
  core_msg_o  output  DATA_WIDTH  word to core message_in
  core_dv_o  output  1  word strobe to core MP_dv
  core_hash_i  input  8  core hash_out byte
  core_dv_i  input  1  core core_dv_flag
  hash_byte_o  output  8  registered hash byte to owner
  hash_dv_o  output  2  per-requester hash byte valid
  done_o  output  2  per-requester transaction complete pulse
  err_o  output  2  per-requester timeout pulse

Function
REQ-005 Single clock domain; asynchronous active-low reset; all outputs registered.
REQ-006 States: IDLE, GRANT, LOAD, WAIT, RETURN, RELEASE.
REQ-007 IDLE: if any req_i bit high -> GRANT next cycle, owner latched.
REQ-008 Arbitration round-robin: single request wins; both requests -> requester other than last_owner wins; last_owner resets to 1 (requester 0 wins first tie).
REQ-009 GRANT: grant_o one-hot for owner from GRANT until RELEASE exit; word/gap counters cleared; -> LOAD.
REQ-010 LOAD: when gap counter is 0 and owner word_valid_i high: capture owner word into core_msg_o, pulse core_dv_o and owner word_ready_o for 1 cycle, load gap counter WORD_GAP-1, increment word count.
REQ-011 core_msg_o held stable for WORD_GAP cycles after each strobe; no strobe while gap counter nonzero.
REQ-012 After 16th word accepted and its gap elapsed -> WAIT; word count 4 bits wrapping to 0 on the 16th word, qualified by a 16-seen flag.
REQ-013 Non-owner word_valid_i ignored; non-owner word_ready_o, hash_dv_o, done_o, err_o stay 0.
REQ-014 WAIT: timeout counter increments each cycle; core_dv_i high -> RETURN, byte counter 0; counter reaching WAIT_TIMEOUT-1 without core_dv_i -> pulse owner err_o, -> RELEASE.
REQ-015 RETURN: each cycle core_dv_i high: hash_byte_o <= core_hash_i, owner hash_dv_o high next cycle, byte counter +1; cycles with core_dv_i low emit nothing.
REQ-016 32nd byte forwarded -> pulse owner done_o same cycle as 32nd hash_dv_o -> RELEASE.
REQ-017 RELEASE: 1 cycle; last_owner <= owner; grant_o <= 0; -> IDLE; new request serviced from IDLE next cycle.
REQ-018 Owner dropping req_i after GRANT has no effect; transaction runs to done or timeout.
REQ-019 core_dv_i outside WAIT/RETURN is ignored and not forwarded.
REQ-020 Illegal state encoding -> IDLE next cycle, outputs to reset values.

Reset
REQ-021 On rst_n low, asynchronously: state IDLE, grant_o 0, core_dv_o 0, core_msg_o 0, word_ready_o 0, hash_byte_o 0, hash_dv_o 0, done_o 0, err_o 0, all counters 0, last_owner 1.
REQ-022 Reset mid-transaction abandons it with no done_o or err_o; first post-reset tie goes to requester 0.

Verification
REQ-023 Requester 0 alone, words 0x61626380, 0x0 x14, 0x18, core returns 32 bytes -> 16 core_dv_o pulses 3 cycles apart, 32 hash_dv_o[0], done_o[0] pulse, grant_o 2'b01 then 0.
REQ-024 Both req_i high from reset -> grant 2'b01; after done, req still 2'b11 -> grant 2'b10; third -> 2'b01.
REQ-025 Owner word_valid_i gapped (high every 7 cycles) -> exactly 16 strobes, core_msg_o stable for 3 cycles per word, requester 1 words never appear.
REQ-026 core_dv_i never asserted in WAIT -> err_o[owner] pulse WAIT_TIMEOUT cycles after entering WAIT, no done_o, grant released, next requester granted.
REQ-027 rst_n pulsed low at 8th word -> all outputs 0 same cycle, IDLE; subsequent full transaction completes normally.
REQ-028 core_dv_i toggling in RETURN (1 high, 1 low) -> 32 bytes forwarded in order, done_o after 32nd.
